// File: rtl/framewriter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | framewriter_pkg: FSM state encoding, AXI constants, burst helpers.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package framewriter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_ADDR      = 3'd2,
    S_DATA      = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;

  function automatic int burst_bytes(input int len, input int data_width);
    return len * (data_width / 8);
  endfunction

  function automatic logic [2:0] size_code(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/framewriter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | framewriter_if: AXI4 write-address, write-data and write-response bundle. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface framewriter_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/framewriter_fw_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fw_fifo: synchronous FIFO with occupancy count; head is valid when count>0|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fw_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         head,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/framewriter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | framewriter: AXI4 INCR-burst frame writer fed by a valid/ready pixel port.|
// | Optional macro FRAMEWRITER_BRESP_CHECK_EN enables sticky BRESP error flag.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module framewriter
  import framewriter_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int FRAME_WORDS        = 153600,
  parameter int FIFO_DEPTH         = 32
) (
  input  wire logic                          M_AXI_ACLK,
  input  wire logic                          M_AXI_ARESETN,
  input  wire logic                          start,
  input  wire logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  wire logic [C_M_AXI_DATA_WIDTH-1:0] pixel_data,
  input  wire logic                          pixel_valid,
  output logic                               pixel_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  framewriter_if.master                      m_axi
);
  localparam int CNT_W      = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W     = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]              FRAME_CNT  = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0]              BURST_CNT  = CNT_W'(C_M_AXI_BURST_LEN);
  localparam logic [FIFO_CNT_W-1:0]         BURST_FILL = FIFO_CNT_W'(C_M_AXI_BURST_LEN);
  localparam logic [BEAT_W-1:0]             LAST_BEAT  = BEAT_W'(C_M_AXI_BURST_LEN - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_STEP =
    C_M_AXI_ADDR_WIDTH'(burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH));

  wire clk   = M_AXI_ACLK;
  wire rst_n = M_AXI_ARESETN;

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
  logic [CNT_W-1:0]                in_cnt;
  logic [CNT_W-1:0]                out_cnt;
  logic [CNT_W-1:0]                out_next;
  logic [BEAT_W-1:0]               beat;
  logic [BEAT_W-1:0]               beat_next;
  logic                            awvalid_q, wvalid_q, wlast_q, bready_q, busy_q, done_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   fifo_head;
  logic [FIFO_CNT_W-1:0]           fifo_count;
  logic                            fifo_full;
  logic                            push;
  logic                            pop;

  assign pixel_ready = busy_q & ~fifo_full & (in_cnt < FRAME_CNT);
  assign push        = pixel_valid & pixel_ready;
  assign pop         = wvalid_q & m_axi.wready;
  assign out_next    = out_cnt + BURST_CNT;
  assign beat_next   = beat + 1'b1;

  fw_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pixel_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = addr;
  assign m_axi.awlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.awsize  = size_code(C_M_AXI_DATA_WIDTH);
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_BUFMOD;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid_q;
  // Head is gated so WDATA reads zero outside a burst, including after reset.
  assign m_axi.wdata   = wvalid_q ? fifo_head : '0;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      beat      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) in_cnt <= in_cnt + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          addr    <= base_addr;
          in_cnt  <= '0;
          out_cnt <= '0;
          busy_q  <= 1'b1;
          state   <= S_WAIT_DATA;
        end
        S_WAIT_DATA: if (fifo_count >= BURST_FILL) begin
          awvalid_q <= 1'b1;
          state     <= S_ADDR;
        end
        S_ADDR: if (m_axi.awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wlast_q   <= (C_M_AXI_BURST_LEN == 1);
          beat      <= '0;
          state     <= S_DATA;
        end
        S_DATA: if (m_axi.wready) begin
          beat    <= beat_next;
          wlast_q <= (beat_next == LAST_BEAT);
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: if (m_axi.bvalid) begin
          bready_q <= 1'b0;
          addr     <= addr + BURST_STEP;
          out_cnt  <= out_next;
          if (out_next == FRAME_CNT) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_WAIT_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // BID is never consulted: only one burst is ever outstanding.
  wire unused_bid = ^m_axi.bid;

`ifdef FRAMEWRITER_BRESP_CHECK_EN
  logic error_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      error_q <= 1'b0;
    else if (state == S_IDLE && start)
      error_q <= 1'b0;
    else if (state == S_RESP && m_axi.bvalid && m_axi.bresp != AXI_RESP_OKAY)
      error_q <= 1'b1;
  end
  assign error = error_q;
`else
  wire unused_bresp = ^m_axi.bresp;
  assign error = 1'b0;
`endif
endmodule
`default_nettype wire
